// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-port OBI memory arbiter.
package obi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_P0 = 2'd1,
        RSP_P1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves after a contended grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       rr_ptr
);

    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            if (req == 2'b11) gnt = rr_ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)             rr_ptr <= 1'b0;
        else if (req == 2'b11)  rr_ptr <= ~rr_ptr;
    end

endmodule

// File: rtl/obi_mem_arb2.sv
// Two-port OBI arbiter in front of one word-aligned data memory: round-robin grant,
// range check, and a one-cycle registered response to the port that was granted.
module obi_mem_arb2
    import obi_arb_pkg::*;
#(
    parameter int          MEM_WIDTH = 6,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req_i,
    output logic        p0_gnt_o,
    input  logic [31:0] p0_addr_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_wdata_i,
    output logic        p0_rvalid_o,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,
    input  logic        p1_req_i,
    output logic        p1_gnt_o,
    input  logic [31:0] p1_addr_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p1_rvalid_o,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_err_i,
    output logic [1:0]  dbg_state,
    output logic        dbg_rr_ptr
);

    // Handshake: a request transfers in the cycle where req && gnt; the manager holds
    // addr/we/be/wdata stable until then. Exactly one rvalid pulse follows, next cycle.
    logic [1:0] gnt;
    logic       rr_ptr;
    logic       granted;
    logic       range_err;
    obi_req_t   p0_req, p1_req, sel;
    obi_rsp_t   rsp_next, p0_rsp_q, p1_rsp_q;
    arb_state_e state;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({p1_req_i, p0_req_i}),
        .gnt    (gnt),
        .rr_ptr (rr_ptr)
    );

    assign p0_gnt_o = gnt[0];
    assign p1_gnt_o = gnt[1];
    assign granted  = |gnt;

    assign p0_req = '{addr: p0_addr_i, we: p0_we_i, be: p0_be_i, wdata: p0_wdata_i};
    assign p1_req = '{addr: p1_addr_i, we: p1_we_i, be: p1_be_i, wdata: p1_wdata_i};
    assign sel    = gnt[1] ? p1_req : p0_req;

    assign range_err = |sel.addr[31:MEM_WIDTH+2];

    always_comb begin
        mem_we_o = 1'b0;
        mem_be_o = 4'b1111;
        mem_a_o  = 32'd0;
        mem_wd_o = 32'd0;
        if (granted) begin
            mem_we_o = sel.we & ~range_err;
            mem_be_o = sel.be;
            mem_a_o  = sel.addr;
            mem_wd_o = sel.wdata;
        end
    end

    // Writes complete with rdata=0; any failure overrides with the error pattern.
    always_comb begin
        rsp_next.rvalid = granted;
        rsp_next.err    = range_err | mem_err_i;
        if (rsp_next.err)  rsp_next.rdata = ERR_RDATA;
        else if (sel.we)   rsp_next.rdata = 32'd0;
        else               rsp_next.rdata = mem_rd_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            p0_rsp_q <= '0;
            p1_rsp_q <= '0;
        end else begin
            if (gnt[0])      state <= RSP_P0;
            else if (gnt[1]) state <= RSP_P1;
            else             state <= IDLE;
            p0_rsp_q <= gnt[0] ? rsp_next : '0;
            p1_rsp_q <= gnt[1] ? rsp_next : '0;
        end
    end

    assign p0_rvalid_o = p0_rsp_q.rvalid;
    assign p0_rdata_o  = p0_rsp_q.rdata;
    assign p0_err_o    = p0_rsp_q.err;
    assign p1_rvalid_o = p1_rsp_q.rvalid;
    assign p1_rdata_o  = p1_rsp_q.rdata;
    assign p1_err_o    = p1_rsp_q.err;
    assign dbg_state   = state;
    assign dbg_rr_ptr  = rr_ptr;

endmodule
